scan_access_arbiter: RTL and testbench

Round-robin arbiter that shares the single scan-chain controller between several requesters (host pins, on-chip test sequencer, debug port). Each requester asks for one complete scan transaction on a chosen design (select + inputs). The arbiter drives the controller's `active_select`/`inputs`, discards the in-flight scan cycle, captures `outputs` from the next full cycle and returns them with a done pulse. It sits between the requester logic and the `active_select`/`inputs`/`outputs`/`ready` port of the scan controller.

---
 rtl/scan_access_arbiter_if.sv | 29 ++
 rtl/scan_access_arbiter.sv | 109 ++++++++++
 tb/tb_scan_access_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/scan_access_arbiter_if.sv
// Requester-side and scan-controller-side signals of the scan access arbiter.
interface scan_access_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 9,
  parameter int IO_W    = 8
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*SEL_W-1:0] req_select;
  logic [NUM_REQ*IO_W-1:0]  req_inputs;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [IO_W-1:0]          resp_outputs;
  logic                     resp_error;
  logic                     busy;
  logic [SEL_W-1:0]         active_select;
  logic [IO_W-1:0]          inputs;
  logic [IO_W-1:0]          outputs;
  logic                     ready;

  modport slave (
    input  req, req_select, req_inputs, outputs, ready,
    output grant, done, resp_outputs, resp_error, busy, active_select, inputs
  );

  modport master (
    output req, req_select, req_inputs, outputs, ready,
    input  grant, done, resp_outputs, resp_error, busy, active_select, inputs
  );
endinterface

// File: rtl/scan_access_arbiter.sv
// Round-robin sharing of one scan controller; one transaction = flush one scan
// cycle, capture the next, pulse done. Each wait state is bounded by TIMEOUT.
module scan_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 9,
  parameter int IO_W    = 8,
  parameter int TIMEOUT = 65535
) (
  input logic                 clk,
  input logic                 reset,
  scan_access_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, RESULT, DONE} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_q;
  logic [PTR_W-1:0]   rr_ptr;
  logic [15:0]        tmo_cnt;
  logic [IO_W-1:0]    resp_q;
  logic               err_q;
  logic [SEL_W-1:0]   sel_q;
  logic [IO_W-1:0]    in_q;

  logic               found;
  logic [PTR_W-1:0]   win_idx;
  int                 idx;
  logic               tmo_hit;

  // Search starts at rr_ptr and wraps, so the last winner goes to the back.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found   = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = FLUSH;
      FLUSH:   if (bus.ready) state_nxt = RESULT;
               else if (tmo_hit) state_nxt = DONE;
      RESULT:  if (bus.ready || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_ptr  <= '0;
      tmo_cnt <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      in_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            grant_q <= NUM_REQ'(1) << win_idx;
            sel_q   <= bus.req_select[int'(win_idx)*SEL_W +: SEL_W];
            in_q    <= bus.req_inputs[int'(win_idx)*IO_W +: IO_W];
            rr_ptr  <= (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + PTR_W'(1);
            tmo_cnt <= '0;
          end
        end
        FLUSH, RESULT: begin
          // The counter restarts when FLUSH hands over to RESULT.
          if (bus.ready) begin
            tmo_cnt <= '0;
            if (state == RESULT) begin
              resp_q <= bus.outputs;
              err_q  <= 1'b0;
            end
          end else if (tmo_hit) begin
            resp_q <= '0;
            err_q  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        DONE:    grant_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.grant         = grant_q;
  assign bus.done          = (state == DONE) ? grant_q : '0;
  assign bus.busy          = (state != IDLE);
  assign bus.resp_outputs  = resp_q;
  assign bus.resp_error    = err_q;
  assign bus.active_select = sel_q;
  assign bus.inputs        = in_q;
endmodule

// File: tb/tb_scan_access_arbiter.sv
// Directed bench for scan_access_arbiter with TIMEOUT shortened to 20.
module tb_scan_access_arbiter;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 9;
  localparam int IO_W    = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  scan_access_arbiter_if #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W), .IO_W(IO_W)) bus ();

  scan_access_arbiter #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W), .IO_W(IO_W), .TIMEOUT(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " grant"}, 32'(bus.grant), 0);
    check({tag, " done"}, 32'(bus.done), 0);
    check({tag, " busy"}, 32'(bus.busy), 0);
    check({tag, " resp"}, 32'(bus.resp_outputs), 0);
    check({tag, " err"}, 32'(bus.resp_error), 0);
    check({tag, " sel"}, 32'(bus.active_select), 0);
    check({tag, " inputs"}, 32'(bus.inputs), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_ready(input logic [7:0] val);
    bus.ready   = 1'b1;
    bus.outputs = val;
    tick();
    bus.ready   = 1'b0;
    bus.outputs = 8'hEE;
  endtask

  // Entered at a negedge in IDLE with req set up; leaves at a negedge in IDLE.
  task automatic run_txn(input int exp_grant, input int exp_sel, input int exp_in,
                         input logic [7:0] data, input bit drop, input string tag);
    tick();
    check({tag, " grant"}, 32'(bus.grant), exp_grant);
    check({tag, " sel"}, 32'(bus.active_select), exp_sel);
    check({tag, " inputs"}, 32'(bus.inputs), exp_in);
    if (drop) bus.req = '0;
    tick();
    pulse_ready(8'h11);
    check({tag, " no done after flush"}, 32'(bus.done), 0);
    tick();
    pulse_ready(data);
    check({tag, " done"}, 32'(bus.done), exp_grant);
    check({tag, " resp"}, 32'(bus.resp_outputs), 32'(data));
    check({tag, " err"}, 32'(bus.resp_error), 0);
    tick();
    check({tag, " done cleared"}, 32'(bus.done), 0);
    check({tag, " grant cleared"}, 32'(bus.grant), 0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.req        = '0;
    bus.req_select = '0;
    bus.req_inputs = '0;
    bus.ready      = 1'b0;
    bus.outputs    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_select[i*SEL_W +: SEL_W] = SEL_W'(16 + i);
      bus.req_inputs[i*IO_W +: IO_W]   = IO_W'(8'h40 + i);
    end
    tick();
    do_reset();
    check_all_zero("reset");

    // Single request: flush output 0x11 must never reach resp_outputs.
    bus.req_select[0 +: SEL_W] = 9'd5;
    bus.req_inputs[0 +: IO_W]  = 8'hA5;
    bus.req = 4'b0001;
    tick();
    check("single grant", 32'(bus.grant), 1);
    check("single busy", 32'(bus.busy), 1);
    check("single sel", 32'(bus.active_select), 5);
    check("single inputs", 32'(bus.inputs), 32'h A5);
    bus.req = '0;
    tick();
    pulse_ready(8'h11);
    check("single resp after flush", 32'(bus.resp_outputs), 0);
    check("single no early done", 32'(bus.done), 0);
    tick();
    pulse_ready(8'h3C);
    check("single done", 32'(bus.done), 1);
    check("single resp", 32'(bus.resp_outputs), 32'h3C);
    check("single err", 32'(bus.resp_error), 0);
    tick();
    check("single done one cycle", 32'(bus.done), 0);
    check("single idle", 32'(bus.busy), 0);
    check("single resp held", 32'(bus.resp_outputs), 32'h3C);
    check("single sel held", 32'(bus.active_select), 5);
    bus.req_select[0 +: SEL_W] = 9'd16;
    bus.req_inputs[0 +: IO_W]  = 8'h40;

    // Fairness: all requesting, strict rotation from 0.
    do_reset();
    bus.req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      run_txn(1 << (t % 4), 16 + (t % 4), 32'h40 + (t % 4), 8'(8'h80 + t), 1'b0,
              $sformatf("fair%0d", t));
    end
    bus.req = '0;

    // Withdrawn request still completes to its own index.
    do_reset();
    bus.req = 4'b0100;
    run_txn(4, 18, 32'h42, 8'h77, 1'b1, "withdraw");

    // Timeout: 21 FLUSH cycles then DONE, resp forced to 0 over previous 0x77.
    bus.req = 4'b0001;
    tick();
    check("tmo grant", 32'(bus.grant), 1);
    bus.req = '0;
    for (int c = 0; c < 20; c++) tick();
    check("tmo not yet", 32'(bus.done), 0);
    check("tmo still busy", 32'(bus.busy), 1);
    tick();
    check("tmo done", 32'(bus.done), 1);
    check("tmo err", 32'(bus.resp_error), 1);
    check("tmo resp", 32'(bus.resp_outputs), 0);
    tick();
    check("tmo idle", 32'(bus.busy), 0);

    // Coincident ready at the arbitration edge is not counted.
    bus.req     = 4'b0010;
    bus.ready   = 1'b1;
    bus.outputs = 8'h99;
    tick();
    bus.ready = 1'b0;
    bus.req   = '0;
    check("coinc grant", 32'(bus.grant), 2);
    tick();
    pulse_ready(8'h55);
    check("coinc no done", 32'(bus.done), 0);
    check("coinc busy", 32'(bus.busy), 1);
    tick();
    pulse_ready(8'h66);
    check("coinc done", 32'(bus.done), 2);
    check("coinc resp", 32'(bus.resp_outputs), 32'h66);
    check("coinc err", 32'(bus.resp_error), 0);
    tick();

    // Reset in RESULT aborts silently and rewinds rr_ptr.
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    tick();
    pulse_ready(8'h11);
    check("rst in result busy", 32'(bus.busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rst mid");
    for (int c = 0; c < 3; c++) begin
      pulse_ready(8'h22);
      check("rst no done", 32'(bus.done), 0);
    end
    bus.req = 4'b1010;
    tick();
    check("rst rr grant", 32'(bus.grant), 2);
    bus.req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
